// File: rtl/battleship_game_ctrl_pkg.sv
// rtl/battleship_game_ctrl_pkg.sv - shared board geometry, cell codes and FSM encoding for the battleship controller
package battleship_definitions;

    localparam int GRID       = 10;
    localparam int CELL_W     = 3;
    localparam int NUM_SHIPS  = 5;
    localparam int CELLS      = GRID * GRID;
    localparam int BOARD_SIZE = CELLS * CELL_W;

    localparam logic [CELL_W-1:0] CELL_WATER = 3'd0;
    localparam logic [CELL_W-1:0] CELL_HIT   = 3'd6;
    localparam logic [CELL_W-1:0] CELL_MISS  = 3'd7;

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        AIM   = 3'd1,
        CHECK = 3'd2,
        SCAN  = 3'd3,
        SWAP  = 3'd4,
        OVER  = 3'd5
    } state_t;

    // Hides intact ship IDs so only water, hits and misses remain visible.
    function automatic logic [BOARD_SIZE-1:0] fog_mask(input logic [BOARD_SIZE-1:0] board);
        logic [BOARD_SIZE-1:0] masked;
        logic [CELL_W-1:0]     code;
        masked = board;
        for (int i = 0; i < CELLS; i++) begin
            code = board[i*CELL_W +: CELL_W];
            if (code != CELL_WATER && code != CELL_HIT && code != CELL_MISS)
                masked[i*CELL_W +: CELL_W] = CELL_WATER;
        end
        return masked;
    endfunction

endpackage

// File: rtl/battleship_game_ctrl_edge_detect.sv
// rtl/battleship_game_ctrl_edge_detect.sv - one-cycle pulse on a 0->1 transition of a debounced level
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_prev <= 1'b0;
        else     r_prev <= level;
    end

    assign pulse = level & ~r_prev;

endmodule

// File: rtl/battleship_game_ctrl.sv
// rtl/battleship_game_ctrl.sv - turn-based battleship controller: cursor, shot resolution, sink scan, win detection
// Optional macro FOG_OF_WAR_EN masks intact ship codes on the board outputs.
module battleship_game_ctrl
    import battleship_definitions::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_l,
    input  logic                  btn_r,
    input  logic                  btn_u,
    input  logic                  btn_d,
    input  logic                  btn_c,
    input  logic [BOARD_SIZE-1:0] p1_layout,
    input  logic [BOARD_SIZE-1:0] p2_layout,
    output logic [BOARD_SIZE-1:0] p1_board,
    output logic [BOARD_SIZE-1:0] p2_board,
    output logic [2:0]            p1_ships,
    output logic [2:0]            p2_ships,
    output logic [3:0]            cursor_x,
    output logic [3:0]            cursor_y,
    output logic                  turn,
    output logic [1:0]            winner,
    output logic [2:0]            state
);

    localparam logic [3:0] MAX_C = 4'(GRID - 1);

    state_t                r_state, w_state_nxt;
    logic [BOARD_SIZE-1:0] r_p1_board, r_p2_board, w_opp_board;
    logic [2:0]            r_p1_ships, r_p2_ships, w_opp_ships;
    logic [3:0]            r_cx, r_cy;
    logic                  r_turn;
    logic [1:0]            r_winner;
    logic [6:0]            r_scan_idx, w_tgt_idx;
    logic [8:0]            w_tgt_bit, w_scan_bit;
    logic [CELL_W-1:0]     r_ship_id, w_tgt_code, w_scan_code;
    logic                  r_found, w_found_now, w_scan_last, w_rejected;
    logic                  w_pl, w_pr, w_pu, w_pd, w_pc;

    edge_detect u_ed_l (.clk(clk), .rst(rst), .level(btn_l), .pulse(w_pl));
    edge_detect u_ed_r (.clk(clk), .rst(rst), .level(btn_r), .pulse(w_pr));
    edge_detect u_ed_u (.clk(clk), .rst(rst), .level(btn_u), .pulse(w_pu));
    edge_detect u_ed_d (.clk(clk), .rst(rst), .level(btn_d), .pulse(w_pd));
    edge_detect u_ed_c (.clk(clk), .rst(rst), .level(btn_c), .pulse(w_pc));

    // The player on turn always fires at the other player's board.
    assign w_opp_board = r_turn ? r_p1_board : r_p2_board;
    assign w_opp_ships = r_turn ? r_p1_ships : r_p2_ships;
    assign w_tgt_idx   = 7'(r_cy) * 7'(GRID) + 7'(r_cx);
    assign w_tgt_bit   = 9'(w_tgt_idx) * 9'(CELL_W);
    assign w_scan_bit  = 9'(r_scan_idx) * 9'(CELL_W);
    assign w_tgt_code  = w_opp_board[w_tgt_bit +: CELL_W];
    assign w_scan_code = w_opp_board[w_scan_bit +: CELL_W];
    assign w_rejected  = (w_tgt_code == CELL_HIT) || (w_tgt_code == CELL_MISS);
    assign w_scan_last = (r_scan_idx == 7'(CELLS - 1));
    assign w_found_now = r_found || (w_scan_code == r_ship_id);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= LOAD;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD:  w_state_nxt = AIM;
            AIM:   if (w_pc) w_state_nxt = CHECK;
            CHECK: begin
                if (w_rejected)                    w_state_nxt = AIM;
                else if (w_tgt_code == CELL_WATER) w_state_nxt = SWAP;
                else                               w_state_nxt = SCAN;
            end
            SCAN: begin
                if (w_scan_last) begin
                    if (!w_found_now && w_opp_ships <= 3'd1) w_state_nxt = OVER;
                    else                                     w_state_nxt = SWAP;
                end
            end
            SWAP:    w_state_nxt = AIM;
            OVER:    w_state_nxt = OVER;
            default: w_state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1_board <= '0;
            r_p2_board <= '0;
            r_p1_ships <= 3'(NUM_SHIPS);
            r_p2_ships <= 3'(NUM_SHIPS);
            r_cx       <= 4'd0;
            r_cy       <= 4'd0;
            r_turn     <= 1'b0;
            r_winner   <= 2'd0;
            r_scan_idx <= 7'd0;
            r_ship_id  <= CELL_WATER;
            r_found    <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_p1_board <= p1_layout;
                    r_p2_board <= p2_layout;
                end
                AIM: begin
                    if (!w_pc) begin
                        if (w_pl)      r_cx <= (r_cx == 4'd0)  ? MAX_C : r_cx - 4'd1;
                        else if (w_pr) r_cx <= (r_cx == MAX_C) ? 4'd0  : r_cx + 4'd1;
                        else if (w_pu) r_cy <= (r_cy == 4'd0)  ? MAX_C : r_cy - 4'd1;
                        else if (w_pd) r_cy <= (r_cy == MAX_C) ? 4'd0  : r_cy + 4'd1;
                    end
                end
                CHECK: begin
                    r_found    <= 1'b0;
                    r_scan_idx <= 7'd0;
                    if (w_tgt_code == CELL_WATER) begin
                        if (r_turn) r_p1_board[w_tgt_bit +: CELL_W] <= CELL_MISS;
                        else        r_p2_board[w_tgt_bit +: CELL_W] <= CELL_MISS;
                    end else if (!w_rejected) begin
                        r_ship_id <= w_tgt_code;
                        if (r_turn) r_p1_board[w_tgt_bit +: CELL_W] <= CELL_HIT;
                        else        r_p2_board[w_tgt_bit +: CELL_W] <= CELL_HIT;
                    end
                end
                SCAN: begin
                    r_found    <= w_found_now;
                    r_scan_idx <= w_scan_last ? 7'd0 : r_scan_idx + 7'd1;
                    // No remaining cell of the struck ship: it has sunk.
                    if (w_scan_last && !w_found_now) begin
                        if (r_turn) r_p1_ships <= (r_p1_ships != 3'd0) ? r_p1_ships - 3'd1 : 3'd0;
                        else        r_p2_ships <= (r_p2_ships != 3'd0) ? r_p2_ships - 3'd1 : 3'd0;
                        if (w_opp_ships <= 3'd1) r_winner <= r_turn ? 2'd2 : 2'd1;
                    end
                end
                SWAP:    r_turn <= ~r_turn;
                default: ;
            endcase
        end
    end

`ifdef FOG_OF_WAR_EN
    assign p1_board = fog_mask(r_p1_board);
    assign p2_board = fog_mask(r_p2_board);
`else
    assign p1_board = r_p1_board;
    assign p2_board = r_p2_board;
`endif

    assign p1_ships = r_p1_ships;
    assign p2_ships = r_p2_ships;
    assign cursor_x = r_cx;
    assign cursor_y = r_cy;
    assign turn     = r_turn;
    assign winner   = r_winner;
    assign state    = r_state;

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// tb/tb_battleship_game_ctrl.sv - scoreboard bench for battleship_game_ctrl with directed shots and cursor moves
module tb_battleship_game_ctrl;

    localparam int BS = 300;
    localparam int S_LOAD = 0, S_AIM = 1, S_CHECK = 2, S_SCAN = 3, S_SWAP = 4, S_OVER = 5;
    localparam int K_ST = 0, K_TURN = 1, K_CX = 2, K_CY = 3, K_P1S = 4, K_P2S = 5,
                   K_WIN = 6, K_C1 = 7, K_C2 = 8, K_B1Z = 9, K_B2Z = 10;
    localparam int O_MISS = 0, O_HIT = 1, O_REJ = 2, O_WIN = 3;
    localparam int B_L = 0, B_R = 1, B_U = 2, B_D = 3, B_C = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    btn = 5'b0;
    logic [BS-1:0] p1_layout, p2_layout, p1_board, p2_board;
    logic [2:0]    p1_ships, p2_ships, state;
    logic [3:0]    cursor_x, cursor_y;
    logic          turn;
    logic [1:0]    winner;

    battleship_game_ctrl dut (
        .clk(clk), .rst(rst),
        .btn_l(btn[B_L]), .btn_r(btn[B_R]), .btn_u(btn[B_U]), .btn_d(btn[B_D]), .btn_c(btn[B_C]),
        .p1_layout(p1_layout), .p2_layout(p2_layout),
        .p1_board(p1_board), .p2_board(p2_board),
        .p1_ships(p1_ships), .p2_ships(p2_ships),
        .cursor_x(cursor_x), .cursor_y(cursor_y),
        .turn(turn), .winner(winner), .state(state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    due;
        int    kind;
        int    idx;
        int    val;
        string name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   mt = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int due, input int kind, input int idx, input int val, input string name);
        exp_t e;
        e.due = due; e.kind = kind; e.idx = idx; e.val = val; e.name = name;
        q.push_back(e);
    endtask

    function automatic int got_val(input int kind, input int idx);
        case (kind)
            K_ST:    return int'(state);
            K_TURN:  return int'(turn);
            K_CX:    return int'(cursor_x);
            K_CY:    return int'(cursor_y);
            K_P1S:   return int'(p1_ships);
            K_P2S:   return int'(p2_ships);
            K_WIN:   return int'(winner);
            K_C1:    return int'(p1_board[3*idx +: 3]);
            K_C2:    return int'(p2_board[3*idx +: 3]);
            K_B1Z:   return (p1_board == '0) ? 1 : 0;
            K_B2Z:   return (p2_board == '0) ? 1 : 0;
            default: return -1;
        endcase
    endfunction

    // Monitor: retire every expectation whose due cycle has arrived.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            mon_e = q.pop_front();
            if (mon_e.due < cyc) check({mon_e.name, "_late"}, cyc, mon_e.due);
            else                 check(mon_e.name, got_val(mon_e.kind, mon_e.idx), mon_e.val);
        end
    end

    task automatic tap(input int b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); btn[b] = 1'b1;
            @(negedge clk); btn[b] = 1'b0;
        end
    endtask

    task automatic move(input int b, input int n, input int ex, input int ey);
        tap(b, n);
        push(cyc + 1, K_CX, 0, ex, "cursor_x");
        push(cyc + 1, K_CY, 0, ey, "cursor_y");
    endtask

    // Fires at hand-given cell index; exp_cell/exp_ships are the hand-computed results.
    task automatic fire(input int outcome, input int idx, input int exp_cell, input int exp_ships);
        int k;
        int ck;
        int sk;
        string cn;
        @(negedge clk);
        k  = cyc;
        ck = (mt == 0) ? K_C2 : K_C1;
        sk = (mt == 0) ? K_P2S : K_P1S;
        cn = $sformatf("%s_cell%0d", (mt == 0) ? "p2" : "p1", idx);
        push(k + 1, K_ST, 0, S_CHECK, "state_check");
        case (outcome)
            O_MISS: begin
                push(k + 2, K_ST, 0, S_SWAP, "state_swap");
                push(k + 2, K_TURN, 0, mt, "turn_held_miss");
                push(k + 3, K_TURN, 0, 1 - mt, "turn_toggle_miss");
                push(k + 3, K_ST, 0, S_AIM, "state_aim_after_miss");
                push(k + 3, ck, idx, exp_cell, cn);
                push(k + 3, sk, 0, exp_ships, "ships_after_miss");
                mt = 1 - mt;
            end
            O_REJ: begin
                push(k + 2, K_ST, 0, S_AIM, "state_aim_after_reject");
                push(k + 2, K_TURN, 0, mt, "turn_after_reject");
                push(k + 2, ck, idx, exp_cell, cn);
            end
            default: begin
                push(k + 2, K_ST, 0, S_SCAN, "state_scan");
                push(k + 2, ck, idx, exp_cell, cn);
                push(k + 101, K_ST, 0, S_SCAN, "state_scan_last");
                if (outcome == O_HIT) begin
                    push(k + 102, K_ST, 0, S_SWAP, "state_swap_after_scan");
                    push(k + 102, K_TURN, 0, mt, "turn_held_hit");
                    push(k + 102, sk, 0, exp_ships, "ships_after_hit");
                    push(k + 103, K_TURN, 0, 1 - mt, "turn_toggle_hit");
                    push(k + 103, K_WIN, 0, 0, "winner_none");
                    mt = 1 - mt;
                end else begin
                    push(k + 102, K_ST, 0, S_OVER, "state_over");
                    push(k + 102, K_WIN, 0, 1, "winner_p1");
                    push(k + 102, sk, 0, exp_ships, "ships_final");
                    push(k + 103, K_ST, 0, S_OVER, "state_over_hold");
                    push(k + 103, K_TURN, 0, mt, "turn_frozen");
                end
            end
        endcase
        btn[B_C] = 1'b1;
        @(negedge clk); btn[B_C] = 1'b0;
        while (cyc < k + ((outcome == O_MISS || outcome == O_REJ) ? 5 : 105)) @(negedge clk);
    endtask

    task automatic summary();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: reached cycle %0d, expected finish before 20000", cyc);
        summary();
        $finish;
    end

    initial begin
        p1_layout = '0;
        p2_layout = '0;
        p1_layout[3*99 +: 3] = 3'd3;
        p2_layout[3*0  +: 3] = 3'd1;
        p2_layout[3*40 +: 3] = 3'd2;
        p2_layout[3*41 +: 3] = 3'd2;
        p2_layout[3*42 +: 3] = 3'd2;
        p2_layout[3*55 +: 3] = 3'd3;
        p2_layout[3*66 +: 3] = 3'd4;
        p2_layout[3*77 +: 3] = 3'd5;

        repeat (2) @(negedge clk);
        push(cyc + 1, K_ST, 0, S_LOAD, "rst_state");
        push(cyc + 1, K_CX, 0, 0, "rst_cursor_x");
        push(cyc + 1, K_CY, 0, 0, "rst_cursor_y");
        push(cyc + 1, K_TURN, 0, 0, "rst_turn");
        push(cyc + 1, K_WIN, 0, 0, "rst_winner");
        push(cyc + 1, K_P1S, 0, 5, "rst_p1_ships");
        push(cyc + 1, K_P2S, 0, 5, "rst_p2_ships");
        push(cyc + 1, K_B1Z, 0, 1, "rst_p1_board_zero");
        push(cyc + 1, K_B2Z, 0, 1, "rst_p2_board_zero");
        @(negedge clk); rst = 1'b0;
        push(cyc + 1, K_ST, 0, S_AIM, "load_to_aim");
        push(cyc + 1, K_C2, 40, 2, "load_p2_cell40");
        push(cyc + 1, K_C1, 99, 3, "load_p1_cell99");

        @(negedge clk); btn[B_R] = 1'b1;
        repeat (12) @(negedge clk);
        btn[B_R] = 1'b0;
        push(cyc + 1, K_CX, 0, 1, "held_right_one_step");
        move(B_L, 1, 0, 0);
        move(B_R, 10, 0, 0);
        move(B_L, 1, 9, 0);
        move(B_R, 1, 0, 0);
        move(B_U, 1, 0, 9);
        move(B_D, 1, 0, 0);
        move(B_R, 3, 3, 0);
        move(B_D, 2, 3, 2);

        fire(O_MISS, 23, 7, 5);
        fire(O_MISS, 23, 7, 5);
        fire(O_REJ, 23, 7, 5);
        move(B_L, 3, 0, 2);
        move(B_D, 2, 0, 4);
        fire(O_HIT, 40, 6, 5);
        fire(O_MISS, 40, 7, 5);
        move(B_R, 1, 1, 4);
        fire(O_HIT, 41, 6, 5);
        fire(O_MISS, 41, 7, 5);
        move(B_R, 1, 2, 4);
        fire(O_HIT, 42, 6, 4);
        fire(O_MISS, 42, 7, 5);
        move(B_L, 2, 0, 4);
        move(B_U, 4, 0, 0);
        fire(O_HIT, 0, 6, 3);
        fire(O_MISS, 0, 7, 5);
        move(B_R, 5, 5, 0);
        move(B_D, 5, 5, 5);
        fire(O_HIT, 55, 6, 2);
        fire(O_MISS, 55, 7, 5);
        move(B_R, 1, 6, 5);
        move(B_D, 1, 6, 6);
        fire(O_HIT, 66, 6, 1);
        fire(O_MISS, 66, 7, 5);
        move(B_R, 1, 7, 6);
        move(B_D, 1, 7, 7);
        fire(O_WIN, 77, 6, 0);

        tap(B_R, 1);
        tap(B_C, 1);
        tap(B_U, 1);
        push(cyc + 1, K_ST, 0, S_OVER, "over_ignores_buttons");
        push(cyc + 1, K_CX, 0, 7, "over_cursor_x");
        push(cyc + 1, K_CY, 0, 7, "over_cursor_y");
        push(cyc + 1, K_WIN, 0, 1, "over_winner");
        push(cyc + 1, K_P2S, 0, 0, "over_p2_ships");
        push(cyc + 1, K_P1S, 0, 5, "over_p1_ships");

        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        mt = 0;
        push(cyc + 1, K_ST, 0, S_AIM, "restart_aim");
        begin
            int k;
            @(negedge clk);
            k = cyc;
            btn[B_C] = 1'b1;
            @(negedge clk); btn[B_C] = 1'b0;
            while (cyc < k + 50) @(negedge clk);
            check("mid_scan_state", got_val(K_ST, 0), S_SCAN);
            check("mid_scan_p2_cell0", got_val(K_C2, 0), 6);
            rst = 1'b1;
            #1;
            check("async_rst_state", got_val(K_ST, 0), S_LOAD);
            check("async_rst_p2_board_zero", got_val(K_B2Z, 0), 1);
            check("async_rst_p1_board_zero", got_val(K_B1Z, 0), 1);
            check("async_rst_p2_ships", got_val(K_P2S, 0), 5);
            check("async_rst_p1_ships", got_val(K_P1S, 0), 5);
            @(negedge clk); rst = 1'b0;
            push(cyc + 1, K_ST, 0, S_AIM, "reload_aim");
            push(cyc + 1, K_C2, 0, 1, "reload_p2_cell0");
            push(cyc + 1, K_C1, 99, 3, "reload_p1_cell99");
        end

        repeat (3) @(negedge clk);
        while (q.size() > 0) begin
            mon_e = q.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL %s: never checked, due cycle %0d, now %0d", mon_e.name, mon_e.due, cyc);
        end
        summary();
        $finish;
    end

endmodule

// File: doc/battleship_game_ctrl.md
Name: battleship_game_ctrl

Overview:
Turn-based game controller for the two-player battleship design. It owns both game boards and the remaining-ship counts, and it moves a shared firing cursor from the debounced buttons. It resolves each shot as a hit, miss or sink, and alternates turns until one fleet is destroyed. Its outputs feed the existing SSD (ship counts) and VGA (boards, cursor) blocks.

Parameters:
GRID, 10, board edge length in cells (GRID*GRID cells per board)
CELL_W, 3, bits per cell code
NUM_SHIPS, 5, ships per player; initial value of each ship counter
BOARD_SIZE, GRID*GRID*CELL_W (300), width of each board vector

Ports:
clk  in  1  master clock
rst  in  1  asynchronous, active-high reset
btn_l / btn_r / btn_u / btn_d  in  1 each  debounced level, cursor move
btn_c  in  1  debounced level, fire
p1_layout  in  BOARD_SIZE  P1 fleet layout (codes 0..5 only)
p2_layout  in  BOARD_SIZE  P2 fleet layout
p1_board  out  BOARD_SIZE  P1 board state
p2_board  out  BOARD_SIZE  P2 board state
p1_ships  out  3  P1 ships remaining
p2_ships  out  3  P2 ships remaining
cursor_x  out  4  cursor column 0..GRID-1
cursor_y  out  4  cursor row 0..GRID-1
turn  out  1  0 = P1 firing at p2_board, 1 = P2 firing at p1_board
winner  out  2  0 none, 1 P1, 2 P2
state  out  3  FSM state, for debug/VGA

Behaviour:
- Cell codes: 0 water; 1..5 intact ship with that ID; 6 hit; 7 miss. Cell index = y*GRID+x, located at bits [CELL_W*idx +: CELL_W].
- Reset (async, rst=1): state=LOAD; boards=0; p1_ships=p2_ships=NUM_SHIPS; cursor=(0,0); turn=0; winner=0; scan index=0; edge-detect history=0.
- Every button passes through a rising-edge detector (1-cycle pulse on a 0->1 transition). Pulses are acted on only in AIM; in every other state they are discarded.
- LOAD (1 cycle): copy p1_layout/p2_layout into the boards -> AIM.
- AIM: a fire pulse has priority over all moves -> CHECK, and the cursor does not move. Otherwise at most one move per cycle, priority L>R>U>D. Moves wrap: left at x=0 goes to GRID-1, right at GRID-1 goes to 0; up/down wrap the same way on y.
- CHECK (1 cycle): read the target cell on the opponent board.
  - Code 6 or 7: shot rejected, no write, turn unchanged -> AIM.
  - Code 0: write 7 -> SWAP.
  - Code 1..5: write 6, latch the ship ID -> SCAN.
- SCAN: idx runs 0..GRID*GRID-1, one cell per cycle (100 cycles), and sets a found flag if any cell equals the latched ID. After the last cell:
  - Found: -> SWAP.
  - Not found: decrement the opponent ship counter. If the new count is 0, set winner (turn 0 -> 1, turn 1 -> 2) -> OVER; otherwise -> SWAP.
- SWAP (1 cycle): toggle turn; the cursor is kept -> AIM.
- OVER: holds all outputs; only rst leaves it.
- Latency from the fire edge (the cycle the pulse is seen in AIM):
  - Miss: turn toggles 3 cycles later.
  - Hit without sink: turn toggles 103 cycles later.
  - Rejected shot: back in AIM 2 cycles later.
- Ship counters saturate at 0 and never underflow. Layout contents are not validated.
- rst asserted mid-SCAN or mid-anything aborts immediately to the reset values.

Optional Feature:
FOG_OF_WAR_EN:
- Defined: board outputs are masked so that codes 1..5 appear as 0; internal state is unchanged. Use this for hidden-fleet display.
- Undefined: boards are output raw.

Decomposition:
- Shared package (battleship_definitions): GRID, CELL_W, NUM_SHIPS, BOARD_SIZE, the cell code constants (CELL_WATER=0, CELL_HIT=6, CELL_MISS=7) and the state encoding (LOAD, AIM, CHECK, SCAN, SWAP, OVER).
- One sub-module, edge_detect (clk, rst, level in, pulse out), instantiated 5 times.

Test Plan:
- Reset, then hold btn_r for 12 cycles as a level -> one pulse only, cursor_x=1; 10 separate presses from x=0 -> x wraps to 0.
- P1 fires at (3,2) where p2_layout has code 0 -> p2_board idx 23 = 7, turn=1 exactly 3 cycles after the pulse, p2_ships=5.
- P1 hits one cell of ship 2 (3-cell ship) -> cell = 6, SCAN finds ID 2, p2_ships stays 5, turn toggles 103 cycles after the pulse.
- Fire again at an already hit/missed cell -> no board write, turn unchanged, AIM after 2 cycles.
- Sink all 5 P2 ships -> p2_ships steps 5..0, winner=1, state=OVER, further button presses ignored.
- Assert rst mid-SCAN -> boards=0 and p1_ships=p2_ships=5 immediately, LOAD, then layouts reloaded next cycle.
